// File: rtl/matmul_arb.sv
// Two-requester round-robin arbiter time-sharing one matmul engine between two FOC channels.
// The winner's operands are registered toward the engine; a watchdog frees the engine on a lost done.
module matmul_arb #(
   parameter int D_WIDTH = 16,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               req0,
   input  logic               req1,
   input  logic [1:0]         op0,
   input  logic [1:0]         op1,
   input  logic [D_WIDTH-1:0] a0,
   input  logic [D_WIDTH-1:0] b0,
   input  logic [D_WIDTH-1:0] a1,
   input  logic [D_WIDTH-1:0] b1,
   input  logic [15:0]        sin0,
   input  logic [15:0]        cos0,
   input  logic [15:0]        sin1,
   input  logic [15:0]        cos1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               done0,
   output logic               done1,
   output logic               err0,
   output logic               err1,
   output logic [D_WIDTH-1:0] a_out0,
   output logic [D_WIDTH-1:0] b_out0,
   output logic [D_WIDTH-1:0] a_out1,
   output logic [D_WIDTH-1:0] b_out1,
   output logic               m_start,
   output logic [1:0]         m_op,
   output logic [D_WIDTH-1:0] m_a,
   output logic [D_WIDTH-1:0] m_b,
   output logic [15:0]        m_sin,
   output logic [15:0]        m_cos,
   input  logic [D_WIDTH-1:0] m_a_out,
   input  logic [D_WIDTH-1:0] m_b_out,
   input  logic               m_done,
   output logic               busy
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic            r_last_owner;
   logic            r_owner;
   logic [WD_W-1:0] r_wdog;

   logic            w_grant;
   logic            w_win;
   logic            w_finish;
   logic            w_timeout;

   logic               r_gnt0, r_gnt1, r_done0, r_done1, r_err0, r_err1, r_start;
   logic [D_WIDTH-1:0] r_a_out0, r_b_out0, r_a_out1, r_b_out1;
   logic [1:0]         r_m_op;
   logic [D_WIDTH-1:0] r_m_a, r_m_b;
   logic [15:0]        r_m_sin, r_m_cos;

   // Next-state decode: winner selection in IDLE, completion or watchdog abort in BUSY.
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_win        = 1'b0;
      w_finish     = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req0 && req1) begin
               w_grant = 1'b1;
               w_win   = ~r_last_owner;
            end else if (req0) begin
               w_grant = 1'b1;
               w_win   = 1'b0;
            end else if (req1) begin
               w_grant = 1'b1;
               w_win   = 1'b1;
            end else begin
               w_grant = 1'b0;
            end
            if (w_grant) begin
               w_next_state = ST_BUSY;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A real done beats a simultaneous watchdog expiry.
            if (m_done) begin
               w_finish     = 1'b1;
               w_next_state = ST_IDLE;
            end else if (r_wdog == WD_LAST) begin
               w_finish     = 1'b1;
               w_timeout    = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_BUSY;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Ownership, watchdog, engine operand latch, result capture and pulse outputs.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_last_owner <= 1'b1;
         r_owner      <= 1'b0;
         r_wdog       <= '0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
         r_start      <= 1'b0;
         r_a_out0     <= '0;
         r_b_out0     <= '0;
         r_a_out1     <= '0;
         r_b_out1     <= '0;
         r_m_op       <= 2'b00;
         r_m_a        <= '0;
         r_m_b        <= '0;
         r_m_sin      <= 16'h0000;
         r_m_cos      <= 16'h0000;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_err0  <= 1'b0;
         r_err1  <= 1'b0;
         r_start <= 1'b0;
         if (w_grant) begin
            r_m_op  <= w_win ? op1  : op0;
            r_m_a   <= w_win ? a1   : a0;
            r_m_b   <= w_win ? b1   : b0;
            r_m_sin <= w_win ? sin1 : sin0;
            r_m_cos <= w_win ? cos1 : cos0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_start <= 1'b1;
            r_owner <= w_win;
            r_wdog  <= '0;
         end else if (w_finish) begin
            if (r_owner) begin
               r_done1 <= 1'b1;
               r_err1  <= w_timeout;
               if (!w_timeout) begin
                  r_a_out1 <= m_a_out;
                  r_b_out1 <= m_b_out;
               end
            end else begin
               r_done0 <= 1'b1;
               r_err0  <= w_timeout;
               if (!w_timeout) begin
                  r_a_out0 <= m_a_out;
                  r_b_out0 <= m_b_out;
               end
            end
            r_last_owner <= r_owner;
         end else if (r_state == ST_BUSY) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign done0   = r_done0;
   assign done1   = r_done1;
   assign err0    = r_err0;
   assign err1    = r_err1;
   assign a_out0  = r_a_out0;
   assign b_out0  = r_b_out0;
   assign a_out1  = r_a_out1;
   assign b_out1  = r_b_out1;
   assign m_start = r_start;
   assign m_op    = r_m_op;
   assign m_a     = r_m_a;
   assign m_b     = r_m_b;
   assign m_sin   = r_m_sin;
   assign m_cos   = r_m_cos;
   assign busy    = (r_state == ST_BUSY);

endmodule
